// File: rtl/ara_eoc_pkg.sv
// Shared types and register map for the Ara end-of-computation controller.
// Offsets are relative to the controller base address.
package ara_eoc_pkg;

  localparam logic [4:0] OFF_EXIT  = 5'h00;
  localparam logic [4:0] OFF_EVENT = 5'h08;
  localparam logic [4:0] OFF_WDOG  = 5'h10;
  localparam logic [4:0] OFF_CYCLE = 5'h18;
  localparam int unsigned WIN_BYTES = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_AW,
    WR_GOT_W,
    WR_RESP
  } wr_state_e;

  typedef struct packed {
    logic [62:0] code;
    logic        done;
  } exit_t;

  // Byte-lane merge of a write beat into an existing 64-bit register.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ara_eoc_wdog.sv
// Free-running cycle counter with a limit compare; raises expire_o while the
// count has reached a non-zero limit and the exit word is not yet latched.
module ara_eoc_wdog (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] limit_i,
  input  logic        freeze_i,
  output logic [63:0] count_o,
  output logic        expire_o
);

  logic [63:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (!freeze_i && (count_q != '1)) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o  = count_q;
  assign expire_o = (limit_i != '0) && (count_q >= limit_i) && !freeze_i;

endmodule

// File: rtl/ara_eoc_ctrl.sv
// AXI4-Lite slave holding the exit word, VCD trigger word and watchdog limit.
// Writes commit on the completing handshake edge, in the same edge b_valid_o rises.
module ara_eoc_ctrl
  import ara_eoc_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter logic [63:0] BaseAddr       = 64'hD000_0000,
  parameter logic [63:0] WdogResetLimit = 64'd0,
  parameter logic [62:0] TimeoutCode    = 63'h0DEAD
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [63:0]            exit_o,
  output logic [63:0]            event_trigger_o
);

  localparam logic [AddrWidth-1:0] Base = AddrWidth'(BaseAddr);

  function automatic logic in_window(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = a - Base;
    return (off < AddrWidth'(WIN_BYTES)) && (off[2:0] == 3'b000);
  endfunction

  function automatic logic [4:0] reg_off(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = a - Base;
    return off[4:0];
  endfunction

  wr_state_e            wr_state_q, wr_state_d;
  logic [AddrWidth-1:0] aw_addr_q, wr_addr;
  logic [63:0]          w_data_q, wr_data;
  logic [7:0]           w_strb_q, wr_strb;
  logic                 wr_fire, wr_ok;
  logic [4:0]           wr_sel;
  resp_t                b_resp_q;

  exit_t                exit_q;
  logic [63:0]          event_q, limit_q, cycle_cnt, exit_wr;
  logic                 wd_expire, sw_exit;
  logic                 hit_exit, hit_event, hit_wdog;

  logic                 r_valid_q, rd_ok;
  logic [4:0]           rd_sel;
  logic [63:0]          r_data_q, rd_word;
  resp_t                r_resp_q;

  // Write FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) wr_state_q <= WR_IDLE;
    else       wr_state_q <= wr_state_d;
  end

  // Write FSM: next state
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_valid_i && w_valid_i) wr_state_d = WR_RESP;
        else if (aw_valid_i)         wr_state_d = WR_GOT_AW;
        else if (w_valid_i)          wr_state_d = WR_GOT_W;
      end
      WR_GOT_AW: if (w_valid_i)  wr_state_d = WR_RESP;
      WR_GOT_W:  if (aw_valid_i) wr_state_d = WR_RESP;
      WR_RESP:   if (b_ready_i)  wr_state_d = WR_IDLE;
      default:   wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    wr_fire    = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        aw_ready_o = 1'b1;
        w_ready_o  = 1'b1;
        wr_fire    = aw_valid_i && w_valid_i;
      end
      WR_GOT_AW: begin
        w_ready_o = 1'b1;
        wr_fire   = w_valid_i;
      end
      WR_GOT_W: begin
        aw_ready_o = 1'b1;
        wr_fire    = aw_valid_i;
      end
      WR_RESP:  b_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_valid_i && aw_ready_o) aw_addr_q <= aw_addr_i;
      if (w_valid_i && w_ready_o) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
    end
  end

  // The completing beat may come from the wires or from the half already held.
  assign wr_addr = (wr_state_q == WR_GOT_AW) ? aw_addr_q : aw_addr_i;
  assign wr_data = (wr_state_q == WR_GOT_W)  ? w_data_q  : w_data_i;
  assign wr_strb = (wr_state_q == WR_GOT_W)  ? w_strb_q  : w_strb_i;
  assign wr_ok   = in_window(wr_addr);
  assign wr_sel  = reg_off(wr_addr);

  assign hit_exit  = wr_fire && wr_ok && (wr_sel == OFF_EXIT);
  assign hit_event = wr_fire && wr_ok && (wr_sel == OFF_EVENT);
  assign hit_wdog  = wr_fire && wr_ok && (wr_sel == OFF_WDOG);
  assign exit_wr   = strb_merge(exit_q, wr_data, wr_strb);
  assign sw_exit   = hit_exit && exit_wr[0] && !exit_q.done;

  ara_eoc_wdog u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .limit_i  (limit_q),
    .freeze_i (exit_q.done),
    .count_o  (cycle_cnt),
    .expire_o (wd_expire)
  );

  // Software exit takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_q   <= '0;
      event_q  <= '0;
      limit_q  <= WdogResetLimit;
      b_resp_q <= RESP_OKAY;
    end else begin
      if (sw_exit)        exit_q <= exit_wr;
      else if (wd_expire) exit_q <= '{code: TimeoutCode, done: 1'b1};
      if (hit_event) event_q <= strb_merge(event_q, wr_data, wr_strb);
      if (hit_wdog)  limit_q <= strb_merge(limit_q, wr_data, wr_strb);
      if (wr_fire)   b_resp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign rd_ok  = in_window(ar_addr_i);
  assign rd_sel = reg_off(ar_addr_i);

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      unique case (rd_sel)
        OFF_EXIT:  rd_word = exit_q;
        OFF_EVENT: rd_word = event_q;
        OFF_WDOG:  rd_word = limit_q;
        OFF_CYCLE: rd_word = cycle_cnt;
        default:   rd_word = '0;
      endcase
    end
  end

  // Single outstanding read; data sampled at the ar handshake edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (ar_valid_i && ar_ready_o) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_word;
      r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_valid_q && r_ready_i) begin
      r_valid_q <= 1'b0;
    end
  end

  assign ar_ready_o      = !r_valid_q;
  assign r_valid_o       = r_valid_q;
  assign r_data_o        = r_data_q;
  assign r_resp_o        = r_resp_q;
  assign b_resp_o        = b_resp_q;
  assign exit_o          = exit_q;
  assign event_trigger_o = event_q;

endmodule

// File: tb/tb_ara_eoc_ctrl.sv
// Directed bench for ara_eoc_ctrl: channel ordering, sticky exit, watchdog,
// error responses, backpressure and byte strobes.
module tb_ara_eoc_ctrl;

  localparam logic [63:0] BASE    = 64'hD000_0000;
  localparam logic [63:0] TIMEOUT = {63'h0DEAD, 1'b1};

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] aw_addr;
  logic        aw_valid, aw_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_valid, w_ready;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [63:0] ar_addr;
  logic        ar_valid, ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid, r_ready;
  logic [63:0] exit_w, event_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ara_eoc_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .exit_o(exit_w), .event_trigger_o(event_w)
  );

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_i = 0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, output logic [1:0] resp);
    int  n;
    bit  aw_hs, w_hs, got_b;
    resp = 2'b11;
    got_b = 0;
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1; w_valid = 1;
    n = 0;
    while ((aw_valid || w_valid) && n < 20) begin
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      step();
      if (aw_hs) aw_valid = 0;
      if (w_hs)  w_valid  = 0;
      n++;
    end
    b_ready = 1;
    n = 0;
    while (!b_valid && n < 20) begin
      step();
      n++;
    end
    if (b_valid) begin
      resp = b_resp;
      got_b = 1;
    end
    step();
    b_ready = 0;
    if (aw_valid || w_valid || !got_b) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h got_b=%0d required=1", a, got_b);
      aw_valid = 0; w_valid = 0;
    end
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
    int n;
    bit hs;
    d = '0; resp = 2'b11;
    ar_addr = a; ar_valid = 1;
    n = 0;
    while (ar_valid && n < 20) begin
      hs = ar_ready;
      step();
      if (hs) ar_valid = 0;
      n++;
    end
    r_ready = 1;
    n = 0;
    while (!r_valid && n < 20) begin
      step();
      n++;
    end
    if (r_valid) begin
      d = r_data; resp = r_resp;
    end else begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h r_valid=0 required=1", a);
    end
    step();
    r_ready = 0;
    ar_valid = 0;
  endtask

  task automatic test_reset();
    logic [63:0] c1, c2;
    logic [1:0]  rr;
    apply_reset();
    checks++; if (exit_w !== 64'h0) begin failures++; $display("FAIL rst_exit got=%h exp=0", exit_w); end
    checks++; if (event_w !== 64'h0) begin failures++; $display("FAIL rst_event got=%h exp=0", event_w); end
    checks++; if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin failures++; $display("FAIL rst_readies got=%b exp=111", {aw_ready, w_ready, ar_ready}); end
    checks++; if ({b_valid, r_valid} !== 2'b00) begin failures++; $display("FAIL rst_valids got=%b exp=00", {b_valid, r_valid}); end
    release_reset();
    do_read(BASE + 64'h18, c1, rr);
    do_read(BASE + 64'h18, c2, rr);
    checks++; if (c1 > 64'd10) begin failures++; $display("FAIL rst_count_small got=%0d exp<=10", c1); end
    checks++; if (c2 <= c1) begin failures++; $display("FAIL rst_count_mono got=%0d exp>%0d", c2, c1); end
  endtask

  task automatic test_write_order();
    // AW first, W two cycles later
    apply_reset(); release_reset();
    aw_addr = BASE; aw_valid = 1;
    step();
    aw_valid = 0;
    checks++; if (aw_ready !== 1'b0) begin failures++; $display("FAIL awfirst_aw_ready got=%b exp=0", aw_ready); end
    step();
    w_data = 64'h1; w_strb = 8'hFF; w_valid = 1;
    checks++; if (exit_w !== 64'h0) begin failures++; $display("FAIL awfirst_exit_pre got=%h exp=0", exit_w); end
    step();
    w_valid = 0;
    checks++; if (exit_w !== 64'h1) begin failures++; $display("FAIL awfirst_exit got=%h exp=1", exit_w); end
    checks++; if ({b_valid, b_resp} !== 3'b100) begin failures++; $display("FAIL awfirst_b got=%b exp=100", {b_valid, b_resp}); end
    b_ready = 1; step(); b_ready = 0;
    // W first, AW two cycles later
    apply_reset(); release_reset();
    w_data = 64'h1; w_strb = 8'hFF; w_valid = 1;
    step();
    w_valid = 0;
    checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL wfirst_w_ready got=%b exp=0", w_ready); end
    step();
    aw_addr = BASE; aw_valid = 1;
    checks++; if (exit_w !== 64'h0) begin failures++; $display("FAIL wfirst_exit_pre got=%h exp=0", exit_w); end
    step();
    aw_valid = 0;
    checks++; if (exit_w !== 64'h1) begin failures++; $display("FAIL wfirst_exit got=%h exp=1", exit_w); end
    checks++; if ({b_valid, b_resp} !== 3'b100) begin failures++; $display("FAIL wfirst_b got=%b exp=100", {b_valid, b_resp}); end
    b_ready = 1; step(); b_ready = 0;
  endtask

  task automatic test_exit_sticky();
    logic [1:0]  rs;
    logic [63:0] d;
    apply_reset(); release_reset();
    do_write(BASE, 64'h7, 8'hFF, rs);
    do_write(BASE, 64'h9, 8'hFF, rs);
    checks++; if (exit_w !== 64'h7) begin failures++; $display("FAIL sticky_exit got=%h exp=7", exit_w); end
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL sticky_resp got=%b exp=00", rs); end
    do_read(BASE, d, rs);
    checks++; if (d !== 64'h7) begin failures++; $display("FAIL sticky_readback got=%h exp=7", d); end
    apply_reset(); release_reset();
    do_write(BASE, 64'h6, 8'hFF, rs);
    checks++; if (exit_w !== 64'h0) begin failures++; $display("FAIL even_exit got=%h exp=0", exit_w); end
  endtask

  task automatic test_watchdog();
    logic [1:0]  rs;
    logic [63:0] d, c1, c2;
    int n;
    apply_reset(); release_reset();
    do_write(BASE + 64'h10, 64'd100, 8'hFF, rs);
    do_read(BASE + 64'h10, d, rs);
    checks++; if (d !== 64'd100) begin failures++; $display("FAIL wdog_limit_rb got=%0d exp=100", d); end
    n = 0;
    while (!exit_w[0] && n < 300) begin step(); n++; end
    checks++; if (exit_w !== TIMEOUT) begin failures++; $display("FAIL wdog_exit got=%h exp=%h", exit_w, TIMEOUT); end
    // expiry seen at count 100; the counter advances once more on that edge, then freezes
    do_read(BASE + 64'h18, c1, rs);
    repeat (5) step();
    do_read(BASE + 64'h18, c2, rs);
    checks++; if (c1 !== 64'd101) begin failures++; $display("FAIL wdog_count got=%0d exp=101", c1); end
    checks++; if (c2 !== 64'd101) begin failures++; $display("FAIL wdog_frozen got=%0d exp=101", c2); end
    // lowering the limit below the running count
    apply_reset(); release_reset();
    repeat (30) step();
    checks++; if (exit_w !== 64'h0) begin failures++; $display("FAIL wdog_off got=%h exp=0", exit_w); end
    do_write(BASE + 64'h10, 64'd10, 8'hFF, rs);
    checks++; if (exit_w !== TIMEOUT) begin failures++; $display("FAIL wdog_lower got=%h exp=%h", exit_w, TIMEOUT); end
  endtask

  task automatic test_errors();
    logic [1:0]  rs;
    logic [63:0] d;
    apply_reset(); release_reset();
    do_write(BASE + 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
    checks++; if (rs !== 2'b10) begin failures++; $display("FAIL oow_wresp got=%b exp=10", rs); end
    checks++; if ({exit_w, event_w} !== 128'h0) begin failures++; $display("FAIL oow_state got=%h/%h exp=0/0", exit_w, event_w); end
    do_read(BASE + 64'h13, d, rs);
    checks++; if ({rs, d} !== {2'b10, 64'h0}) begin failures++; $display("FAIL unal_read got=%b/%h exp=10/0", rs, d); end
    // backpressure on B while a new AW is offered
    aw_addr = BASE + 64'h28; w_data = 64'h1; w_strb = 8'hFF; aw_valid = 1; w_valid = 1;
    step();
    w_valid = 0;
    aw_addr = BASE + 64'h08;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({b_valid, b_resp, aw_ready} !== 4'b1100) begin
        failures++; $display("FAIL bhold_%0d got=%b exp=1100", i, {b_valid, b_resp, aw_ready});
      end
      step();
    end
    aw_valid = 0;
    b_ready = 1; step(); b_ready = 0;
    checks++; if ({b_valid, event_w} !== 65'h0) begin failures++; $display("FAIL bhold_after got=%b/%h exp=0/0", b_valid, event_w); end
  endtask

  task automatic test_event_strobe();
    logic [1:0]  rs;
    logic [63:0] d;
    apply_reset(); release_reset();
    do_write(BASE + 64'h08, 64'h1, 8'hFF, rs);
    checks++; if (event_w !== 64'h1) begin failures++; $display("FAIL ev_start got=%h exp=1", event_w); end
    do_write(BASE + 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, rs);
    checks++; if (event_w !== 64'hFFFF_FFFF_0000_0001) begin failures++; $display("FAIL ev_hi got=%h exp=ffffffff00000001", event_w); end
    do_write(BASE + 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rs);
    checks++; if (event_w !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL ev_all got=%h exp=all-ones", event_w); end
    do_read(BASE + 64'h08, d, rs);
    checks++; if ({rs, d} !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFF}) begin failures++; $display("FAIL ev_readback got=%b/%h exp=00/all-ones", rs, d); end
  endtask

  initial begin
    rst_i = 1;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
    #1;
    test_reset();
    test_write_order();
    test_exit_sticky();
    test_watchdog();
    test_errors();
    test_event_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
